// File: rtl/rf_wb_if.sv
// Write-back arbiter bus: ALU result, long-latency handshake, scoreboard
// allocation, and the register-file write port.
interface rf_wb_if;
  logic        alu_we;
  logic [3:0]  alu_addr;
  logic [16:0] alu_data;
  logic        lng_vld;
  logic [3:0]  lng_addr;
  logic [16:0] lng_data;
  logic        lng_rdy;
  logic        alloc_vld;
  logic [3:0]  alloc_addr;
  logic [15:0] busy;
  logic        hold_req;
  logic        we;
  logic [3:0]  dst_addr;
  logic [16:0] dst;

  // pipeline side: drives results and allocations
  modport master (
    output alu_we, alu_addr, alu_data, lng_vld, lng_addr, lng_data,
           alloc_vld, alloc_addr,
    input  lng_rdy, busy, hold_req, we, dst_addr, dst
  );

  // arbiter side
  modport slave (
    input  alu_we, alu_addr, alu_data, lng_vld, lng_addr, lng_data,
           alloc_vld, alloc_addr,
    output lng_rdy, busy, hold_req, we, dst_addr, dst
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter. ALU results always win; long-latency
// results queue in a small FIFO (or bypass it when it is empty and the ALU
// is idle). Tracks pending writes in a busy scoreboard and raises hold_req
// when the FIFO head has been starved for STARVE_MAX cycles.
module rf_wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  rf_wb_if.slave bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [3:0]  addr;
    logic [16:0] data;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty;
  logic          hs, push, pop, bypass, sel_vld, issue;
  logic [3:0]    sel_addr;
  logic [16:0]   sel_data;
  logic [CW-1:0] starve, starve_nxt;
  logic [15:0]   busy_nxt;

  assign full        = (count == (AW+1)'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign bus.lng_rdy = !full;
  assign hs          = bus.lng_vld & !full;

  // priority: ALU, then FIFO head, then direct bypass of a fresh result
  assign pop     = !bus.alu_we & !empty;
  assign bypass  = !bus.alu_we & empty & hs;
  assign push    = hs & !bypass;
  assign sel_vld = bus.alu_we | pop | bypass;

  // select the winning result
  always_comb begin
    sel_addr = bus.lng_addr;
    sel_data = bus.lng_data;
    if (bus.alu_we) begin
      sel_addr = bus.alu_addr;
      sel_data = bus.alu_data;
    end else if (pop) begin
      sel_addr = mem[rd_ptr].addr;
      sel_data = mem[rd_ptr].data;
    end
  end

  // register 0 is a sink: results to it are consumed but never written
  assign issue = sel_vld & (sel_addr != 4'd0);

  // starvation count saturates at STARVE_MAX so hold_req stays up until a pop
  always_comb begin
    starve_nxt = starve;
    if (pop || empty)
      starve_nxt = '0;
    else if (bus.alu_we && starve != CW'(STARVE_MAX))
      starve_nxt = starve + 1'b1;
  end

  // scoreboard: clear on issue, then set on alloc so a newer pending write wins
  always_comb begin
    busy_nxt = bus.busy;
    if (issue)
      busy_nxt[sel_addr] = 1'b0;
    if (bus.alloc_vld)
      busy_nxt[bus.alloc_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{addr: bus.lng_addr, data: bus.lng_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // registered write port; address/data hold when nothing is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.we       <= 1'b0;
      bus.dst_addr <= '0;
      bus.dst      <= '0;
    end else begin
      bus.we <= issue;
      if (issue) begin
        bus.dst_addr <= sel_addr;
        bus.dst      <= sel_data;
      end
    end
  end

  // starvation tracking and hold request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve       <= '0;
      bus.hold_req <= 1'b0;
    end else begin
      starve       <= starve_nxt;
      bus.hold_req <= (starve_nxt == CW'(STARVE_MAX));
    end
  end

  // busy scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.busy <= '0;
    else        bus.busy <= busy_nxt;
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a per-cycle vector table plus a
// hand-written asynchronous reset sequence.
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;

  rf_wb_if bus ();

  rf_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        aw;  logic [3:0] aa; logic [16:0] ad;
    logic        lv;  logic [3:0] la; logic [16:0] ld;
    logic        cv;  logic [3:0] ca;
    logic        rdy;
    logic        we;  logic [3:0] da; logic [16:0] d;
    logic [15:0] busy;
    logic        hold;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  function automatic vec_t mk(
    logic aw, logic [3:0] aa, logic [16:0] ad,
    logic lv, logic [3:0] la, logic [16:0] ld,
    logic cv, logic [3:0] ca, logic rdy,
    logic we, logic [3:0] da, logic [16:0] d,
    logic [15:0] busy, logic hold);
    vec_t v;
    v.aw = aw; v.aa = aa; v.ad = ad;
    v.lv = lv; v.la = la; v.ld = ld;
    v.cv = cv; v.ca = ca; v.rdy = rdy;
    v.we = we; v.da = da; v.d = d;
    v.busy = busy; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic drive(input logic aw, input logic [3:0] aa, input logic [16:0] ad,
                       input logic lv, input logic [3:0] la, input logic [16:0] ld,
                       input logic cv, input logic [3:0] ca);
    bus.alu_we = aw; bus.alu_addr = aa; bus.alu_data = ad;
    bus.lng_vld = lv; bus.lng_addr = la; bus.lng_data = ld;
    bus.alloc_vld = cv; bus.alloc_addr = ca;
  endtask

  initial begin
    // columns: alu(we,addr,data) lng(vld,addr,data) alloc(vld,addr) | rdy | we,dst_addr,dst busy hold
    // basic ALU write then idle
    vt[0]  = mk(1,3,17'h12345, 0,0,0,       0,0, 1, 1,3,17'h12345, 16'h0000,0);
    vt[1]  = mk(0,0,0,         0,0,0,       0,0, 1, 0,0,0,         16'h0000,0);
    // bypass of a long-latency result into an empty FIFO
    vt[2]  = mk(0,0,0,         1,5,17'h000AA,0,0, 1, 1,5,17'h000AA, 16'h0000,0);
    vt[3]  = mk(0,0,0,         0,0,0,       0,0, 1, 0,0,0,         16'h0000,0);
    // ALU busy for 6 cycles while A, B, C are offered
    vt[4]  = mk(1,1,17'h00011, 1,8,17'h00A08,0,0, 1, 1,1,17'h00011, 16'h0000,0);
    vt[5]  = mk(1,2,17'h00012, 1,9,17'h00B09,0,0, 1, 1,2,17'h00012, 16'h0000,0);
    vt[6]  = mk(1,3,17'h00013, 1,10,17'h00C0A,0,0,0, 1,3,17'h00013, 16'h0000,0);
    vt[7]  = mk(1,4,17'h00014, 1,10,17'h00C0A,0,0,0, 1,4,17'h00014, 16'h0000,0);
    vt[8]  = mk(1,5,17'h00015, 1,10,17'h00C0A,0,0,0, 1,5,17'h00015, 16'h0000,1);
    vt[9]  = mk(1,6,17'h00016, 1,10,17'h00C0A,0,0,0, 1,6,17'h00016, 16'h0000,1);
    // drain in order; C is pushed while B pops
    vt[10] = mk(0,0,0,         1,10,17'h00C0A,0,0,0, 1,8,17'h00A08, 16'h0000,0);
    vt[11] = mk(0,0,0,         1,10,17'h00C0A,0,0,1, 1,9,17'h00B09, 16'h0000,0);
    vt[12] = mk(0,0,0,         0,0,0,       0,0, 1, 1,10,17'h00C0A,16'h0000,0);
    vt[13] = mk(0,0,0,         0,0,0,       0,0, 1, 0,0,0,         16'h0000,0);
    // scoreboard: set, set-wins-over-clear, clear
    vt[14] = mk(0,0,0,         0,0,0,       1,7, 1, 0,0,0,         16'h0080,0);
    vt[15] = mk(1,7,17'h00777, 0,0,0,       1,7, 1, 1,7,17'h00777, 16'h0080,0);
    vt[16] = mk(1,7,17'h00778, 0,0,0,       0,0, 1, 1,7,17'h00778, 16'h0000,0);
    // register 0 never written or busy
    vt[17] = mk(1,0,17'h1FFFF, 0,0,0,       1,0, 1, 0,0,0,         16'h0000,0);
    vt[18] = mk(0,0,0,         1,0,17'h00123,0,0, 1, 0,0,0,         16'h0000,0);
    vt[19] = mk(0,0,0,         0,0,0,       0,0, 1, 0,0,0,         16'h0000,0);
    // long-latency write clears its busy bit
    vt[20] = mk(0,0,0,         0,0,0,       1,4, 1, 0,0,0,         16'h0010,0);
    vt[21] = mk(0,0,0,         1,4,17'h00044,0,0, 1, 1,4,17'h00044, 16'h0000,0);

    drive(0,0,0, 0,0,0, 0,0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",   32'(bus.we), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_hold", 32'(bus.hold_req), 0);
    chk("rst_dst",  32'(bus.dst), 0);
    chk("rst_rdy",  32'(bus.lng_rdy), 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].aw, vt[i].aa, vt[i].ad, vt[i].lv, vt[i].la, vt[i].ld, vt[i].cv, vt[i].ca);
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(bus.lng_rdy), 32'(vt[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i), 32'(bus.we), 32'(vt[i].we));
      if (vt[i].we) begin
        chk($sformatf("v%0d_addr", i), 32'(bus.dst_addr), 32'(vt[i].da));
        chk($sformatf("v%0d_dst", i),  32'(bus.dst), 32'(vt[i].d));
      end
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vt[i].busy));
      chk($sformatf("v%0d_hold", i), 32'(bus.hold_req), 32'(vt[i].hold));
    end

    // fill FIFO, raise hold_req and set busy bits, then reset mid-cycle
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(1, 1, 17'(k), 1, 3, 17'h00333, (k < 2), (k == 0) ? 4'd2 : 4'd11);
    end
    @(negedge clk);
    drive(0,0,0, 0,0,0, 0,0);
    #1;
    chk("pre_hold", 32'(bus.hold_req), 1);
    chk("pre_rdy",  32'(bus.lng_rdy), 0);
    chk("pre_busy", 32'(bus.busy), 32'h0804);
    chk("pre_we",   32'(bus.we), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_we",   32'(bus.we), 0);
    chk("arst_addr", 32'(bus.dst_addr), 0);
    chk("arst_dst",  32'(bus.dst), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_hold", 32'(bus.hold_req), 0);
    chk("arst_rdy",  32'(bus.lng_rdy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_we",  32'(bus.we), 0);
    chk("post_rdy", 32'(bus.lng_rdy), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
